// File: rtl/riscv_test_monitor_pkg.sv
// ============================================================================
// Module   : riscv_test_monitor_pkg
// Purpose  : Shared types and constants for the riscv-tests retire monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_test_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;

    localparam logic [4:0] RV_X0 = 5'd0;

endpackage

`default_nettype wire

// File: rtl/commit_trace_ring.sv
// ============================================================================
// Module   : commit_trace_ring
// Purpose  : Ring buffer of recent register-file commits, newest-relative read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_ring
    import riscv_test_monitor_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  trace_entry_t             i_entry,
    input  logic                     i_freeze,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output trace_entry_t             o_rd_entry,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_IDX_W   = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_PTR_ONE = c_IDX_W'(1);
    localparam logic [c_IDX_W:0]   c_CNT_ONE = (c_IDX_W+1)'(1);
    localparam logic [c_IDX_W:0]   c_FULL    = (c_IDX_W+1)'(DEPTH);

    trace_entry_t       r_mem [DEPTH];
    logic [c_IDX_W-1:0] r_wr_ptr;
    logic [c_IDX_W:0]   r_count;
    logic               w_wr;
    logic [c_IDX_W-1:0] w_rd_addr;

    assign w_wr = i_push && !i_freeze;

    // Storage is left unreset; the count gate below hides stale entries.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (r_count != c_FULL) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign w_rd_addr  = r_wr_ptr - c_PTR_ONE - i_rd_idx;
    assign o_rd_entry = ({1'b0, i_rd_idx} < r_count) ? r_mem[w_rd_addr] : '0;
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/riscv_test_monitor.sv
// ============================================================================
// Module   : riscv_test_monitor
// Purpose  : Retire-stream monitor deciding the riscv-tests pass/fail/timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter logic [31:0] END_PC         = 32'h0000_0044,
    parameter logic [31:0] PASS_GP        = 32'h0000_0001,
    parameter int          TIMEOUT_CYCLES = 2480,
    parameter int          TRACE_DEPTH    = 16,
    parameter int          CNT_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    pc_out,
    input  logic [31:0]                    reg3,
    input  logic [31:0]                    debug_wb_pc,
    input  logic [3:0]                     debug_wb_rf_wen,
    input  logic [4:0]                     debug_wb_rf_wnum,
    input  logic [31:0]                    debug_wb_rf_wdata,
    input  logic                           debug_csr_we,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic                           x0_write_err,
    output logic [31:0]                    fail_gp,
    output logic [CNT_W-1:0]               retire_cnt,
    output logic [CNT_W-1:0]               csr_wr_cnt,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic [31:0]                    trace_pc,
    output logic [4:0]                     trace_wnum,
    output logic [31:0]                    trace_wdata
);

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic [31:0]        r_last_wb_pc;
    logic               r_done, r_pass, r_fail, r_timeout, r_x0_err;
    logic [31:0]        r_fail_gp;
    logic [CNT_W-1:0]   r_retire, r_csr, r_cycle;

    logic               w_run, w_commit, w_wen, w_end, w_to_hit, w_push;
    trace_entry_t       w_entry, w_rd_entry;

    assign w_run    = (r_state == ST_RUN);
    assign w_commit = (debug_wb_pc != 32'd0) && (debug_wb_pc != r_last_wb_pc);
    assign w_wen    = (debug_wb_rf_wen != 4'd0);
    assign w_end    = (pc_out == END_PC);
    // END_PC outranks a timeout landing on the same cycle.
    assign w_to_hit = !w_end && (r_cycle == c_TO_LAST);
    assign w_push   = w_run && w_commit && w_wen && (debug_wb_rf_wnum != RV_X0);
    assign w_entry  = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_wb_pc <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_x0_err     <= 1'b0;
            r_fail_gp    <= '0;
            r_retire     <= '0;
            r_csr        <= '0;
            r_cycle      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_out != 32'd0) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_last_wb_pc <= debug_wb_pc;
                    if (w_commit && (r_retire != '1)) begin
                        r_retire <= r_retire + c_CNT_ONE;
                    end
                    if (debug_csr_we && (r_csr != '1)) begin
                        r_csr <= r_csr + c_CNT_ONE;
                    end
                    if (w_commit && w_wen && (debug_wb_rf_wnum == RV_X0)) begin
                        r_x0_err <= 1'b1;
                    end
                    if (!w_to_hit && (r_cycle != '1)) begin
                        r_cycle <= r_cycle + c_CNT_ONE;
                    end
                    if (w_end) begin
                        r_fail_gp <= reg3;
                        r_done    <= 1'b1;
                        if (reg3 == PASS_GP) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (w_to_hit) begin
                        r_state   <= ST_TIMEOUT;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    commit_trace_ring #(
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_entry    (w_entry),
        .i_freeze   (!w_run),
        .i_rd_idx   (trace_rd_idx),
        .o_rd_entry (w_rd_entry),
        .o_count    (trace_count)
    );

    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign x0_write_err = r_x0_err;
    assign fail_gp      = r_fail_gp;
    assign retire_cnt   = r_retire;
    assign csr_wr_cnt   = r_csr;
    assign cycle_cnt    = r_cycle;
    assign trace_pc     = w_rd_entry.pc;
    assign trace_wnum   = w_rd_entry.wnum;
    assign trace_wdata  = w_rd_entry.wdata;

endmodule

`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
// ============================================================================
// Module   : tb_riscv_test_monitor
// Purpose  : Directed, table-driven self-checking bench for riscv_test_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out, reg3, wb_pc, wb_wdata;
    logic [3:0]  wb_wen;
    logic [4:0]  wb_wnum;
    logic        csr_we;
    logic [3:0]  rd_idx;
    logic        done, pass, fail, timeout, x0_err;
    logic [31:0] fail_gp, retire_cnt, csr_wr_cnt, cycle_cnt, trace_pc, trace_wdata;
    logic [4:0]  trace_count, trace_wnum;

    riscv_test_monitor #(
        .END_PC         (32'h0000_0044),
        .PASS_GP        (32'h0000_0001),
        .TIMEOUT_CYCLES (20),
        .TRACE_DEPTH    (16),
        .CNT_W          (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_out            (pc_out),
        .reg3              (reg3),
        .debug_wb_pc       (wb_pc),
        .debug_wb_rf_wen   (wb_wen),
        .debug_wb_rf_wnum  (wb_wnum),
        .debug_wb_rf_wdata (wb_wdata),
        .debug_csr_we      (csr_we),
        .trace_rd_idx      (rd_idx),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .timeout           (timeout),
        .x0_write_err      (x0_err),
        .fail_gp           (fail_gp),
        .retire_cnt        (retire_cnt),
        .csr_wr_cnt        (csr_wr_cnt),
        .cycle_cnt         (cycle_cnt),
        .trace_count       (trace_count),
        .trace_pc          (trace_pc),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] reg3_end;
        logic        exp_pass;
        logic        exp_fail;
        logic [31:0] exp_gp;
    } end_vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_wnum;
        logic [31:0] exp_pc;
    } rd_vec_t;

    end_vec_t end_tbl [4];
    rd_vec_t  rd_tbl  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_out   = 32'd0;
        reg3     = 32'd0;
        wb_pc    = 32'd0;
        wb_wen   = 4'd0;
        wb_wnum  = 5'd0;
        wb_wdata = 32'd0;
        csr_we   = 1'b0;
        rd_idx   = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    // One IDLE cycle with a nonzero fetch PC moves the monitor into RUN.
    task automatic enter_run();
        pc_out = 32'h4;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        end_tbl[0] = '{32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001};
        end_tbl[1] = '{32'h0000_000D, 1'b0, 1'b1, 32'h0000_000D};
        end_tbl[2] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
        end_tbl[3] = '{32'h0000_0002, 1'b0, 1'b1, 32'h0000_0002};

        rd_tbl[0] = '{4'd0,  32'd19, 5'd20, 32'h0000_024C};
        rd_tbl[1] = '{4'd1,  32'd18, 5'd19, 32'h0000_0248};
        rd_tbl[2] = '{4'd7,  32'd12, 5'd13, 32'h0000_0230};
        rd_tbl[3] = '{4'd15, 32'd4,  5'd5,  32'h0000_0210};

        clear_inputs();
        #3;
        check("rst_done",    32'(done), 32'd0);
        check("rst_retire",  retire_cnt, 32'd0);
        check("rst_count",   32'(trace_count), 32'd0);
        check("rst_twdata",  trace_wdata, 32'd0);
        check("rst_failgp",  fail_gp, 32'd0);
        check("rst_x0",      32'(x0_err), 32'd0);

        // End-of-test verdicts: 16 RUN cycles, pc 0x8..0x44, distinct wb_pc.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            enter_run();
            for (int k = 0; k < 16; k++) begin
                pc_out = 32'h8 + 32'(4 * k);
                wb_pc  = 32'h100 + 32'(4 * k);
                csr_we = (k % 3 == 0);
                reg3   = (k == 15) ? end_tbl[v].reg3_end : 32'h0;
                if (k == 15) check("end_done_pre", 32'(done), 32'd0);
                step();
            end
            check("end_done",    32'(done), 32'd1);
            check("end_pass",    32'(pass), 32'(end_tbl[v].exp_pass));
            check("end_fail",    32'(fail), 32'(end_tbl[v].exp_fail));
            check("end_timeout", 32'(timeout), 32'd0);
            check("end_fail_gp", fail_gp, end_tbl[v].exp_gp);
            check("end_retire",  retire_cnt, 32'd16);
            check("end_csr",     csr_wr_cnt, 32'd6);
            pc_out = 32'h48;
            wb_pc  = 32'h140;
            csr_we = 1'b1;
            step();
            check("end_frozen_retire", retire_cnt, 32'd16);
            check("end_frozen_csr",    csr_wr_cnt, 32'd6);
        end

        // Timeout: fetch never reaches END_PC.
        do_reset();
        enter_run();
        for (int c = 1; c <= 20; c++) begin
            pc_out = 32'h8;
            wb_pc  = 32'h400 + 32'(4 * c);
            step();
            if (c == 19) begin
                check("to_pre_flag",  32'(timeout), 32'd0);
                check("to_pre_cycle", cycle_cnt, 32'd19);
            end
        end
        check("to_flag",  32'(timeout), 32'd1);
        check("to_done",  32'(done), 32'd1);
        check("to_pass",  32'(pass), 32'd0);
        check("to_cycle", cycle_cnt, 32'd19);
        for (int c = 0; c < 3; c++) step();
        check("to_cycle_frozen", cycle_cnt, 32'd19);
        check("to_flag_sticky",  32'(timeout), 32'd1);

        // Ring wrap: 20 pushes; the last lands on END_PC just as timeout is due.
        do_reset();
        enter_run();
        for (int i = 0; i < 20; i++) begin
            pc_out   = (i == 19) ? 32'h44 : 32'h8;
            reg3     = 32'h1;
            wb_pc    = 32'h200 + 32'(4 * i);
            wb_wen   = 4'hF;
            wb_wnum  = 5'((i % 31) + 1);
            wb_wdata = 32'(i);
            step();
        end
        check("ring_pass",    32'(pass), 32'd1);
        check("ring_timeout", 32'(timeout), 32'd0);
        check("ring_count",   32'(trace_count), 32'd16);
        check("ring_retire",  retire_cnt, 32'd20);
        for (int r = 0; r < 4; r++) begin
            rd_idx = rd_tbl[r].idx;
            #1;
            check("ring_wdata", trace_wdata, rd_tbl[r].exp_wdata);
            check("ring_wnum",  32'(trace_wnum), 32'(rd_tbl[r].exp_wnum));
            check("ring_pc",    trace_pc, rd_tbl[r].exp_pc);
        end

        // x0 write, repeated wb_pc, then asynchronous reset mid-run.
        do_reset();
        enter_run();
        wb_pc = 32'h300; wb_wen = 4'hF; wb_wnum = 5'd5; wb_wdata = 32'hAA;
        step();
        wb_pc = 32'h304; wb_wnum = 5'd0; wb_wdata = 32'hBB;
        step();
        check("x0_flag",  32'(x0_err), 32'd1);
        check("x0_count", 32'(trace_count), 32'd1);
        wb_pc = 32'h308; wb_wen = 4'h0; wb_wnum = 5'd7;
        for (int h = 0; h < 3; h++) step();
        check("hold_retire", retire_cnt, 32'd3);
        check("x0_sticky",   32'(x0_err), 32'd1);
        rd_idx = 4'd0;
        #1;
        check("x0_rd0_wdata", trace_wdata, 32'hAA);
        check("x0_rd0_wnum",  32'(trace_wnum), 32'd5);
        rd_idx = 4'd1;
        #1;
        check("x0_rd1_empty", trace_wdata, 32'd0);
        wb_pc = 32'h30C;
        step();
        wb_pc = 32'h310;
        step();
        check("pre_rst_retire", retire_cnt, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_retire", retire_cnt, 32'd0);
        check("arst_cycle",  cycle_cnt, 32'd0);
        check("arst_count",  32'(trace_count), 32'd0);
        check("arst_x0",     32'(x0_err), 32'd0);
        check("arst_twdata", trace_wdata, 32'd0);
        step();
        rst = 1'b0;
        clear_inputs();
        enter_run();
        wb_pc = 32'h500;
        step();
        check("rerun_retire", retire_cnt, 32'd1);
        check("rerun_cycle",  cycle_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable retire-stream consumer that sits directly downstream of the CPU top's debug writeback and fetch ports.
- Watches the fetch PC and the writeback debug bus, counts retired instructions, and keeps a ring buffer of the most recent register-file commits.
- Decides the riscv-tests verdict in hardware: pass, fail or timeout.
- Lets the bench, or an FPGA status LED/UART, read one sticky result instead of parsing `$display` logs.

Parameters:
- END_PC, 32'h0000_0044, fetch PC that marks test completion
- PASS_GP, 32'h0000_0001, gp (x3) value meaning pass
- TIMEOUT_CYCLES, 2480, RUN-state cycles before declaring timeout
- TRACE_DEPTH, 16, commit ring entries; must be a power of 2, ≥2
- CNT_W, 32, width of the retire and cycle counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- pc_out  in  32  CPU fetch PC
- reg3  in  32  live gp register value
- debug_wb_pc  in  32  PC of the instruction in writeback
- debug_wb_rf_wen  in  4  writeback byte enables (nonzero = register write)
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- debug_csr_we  in  1  CSR write strobe
- trace_rd_idx  in  log2(TRACE_DEPTH)  0 = newest entry
- done  out  1  sticky; verdict reached
- pass  out  1  sticky
- fail  out  1  sticky
- timeout  out  1  sticky
- x0_write_err  out  1  sticky; wen≠0 with wnum=0 seen
- fail_gp  out  32  gp captured at END_PC
- retire_cnt  out  CNT_W  committed instructions
- csr_wr_cnt  out  CNT_W  CSR writes
- cycle_cnt  out  CNT_W  cycles spent in RUN
- trace_count  out  log2(TRACE_DEPTH)+1  valid entries, saturating
- trace_pc  out  32  entry selected by trace_rd_idx
- trace_wnum  out  5  entry selected by trace_rd_idx
- trace_wdata  out  32  entry selected by trace_rd_idx

Behaviour:
- Reset, async on rst high:
  - state IDLE
  - all flags 0; fail_gp, counters, trace_count and wr_ptr all 0
  - trace storage contents are don't-care, but trace outputs read 0 while trace_count=0
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - IDLE→RUN on the first cycle with pc_out≠0.
  - PASS, FAIL and TIMEOUT are terminal until rst.
- Commit definition, evaluated in RUN only:
  - commit = debug_wb_pc≠0 and debug_wb_pc≠last_wb_pc.
  - last_wb_pc is a register updated every RUN cycle and reset to 0.
  - Each commit increments retire_cnt.
  - A commit with debug_wb_rf_wen≠0 and wnum≠0 pushes {debug_wb_pc, wnum, wdata} at wr_ptr, then wr_ptr+1 mod TRACE_DEPTH.
  - trace_count saturates at TRACE_DEPTH.
  - A commit with wen≠0 and wnum=0 sets x0_write_err and is not pushed.
- csr_wr_cnt increments on each RUN cycle with debug_csr_we=1. It is independent of the commit definition.
- cycle_cnt increments every RUN cycle.
- Counters saturate at all-ones and do not wrap.
- Completion check, in RUN:
  - If pc_out==END_PC, capture fail_gp<=reg3 next edge.
  - Then go to PASS if reg3==PASS_GP, otherwise to FAIL.
  - done and the matching flag assert 1 cycle after the edge that sampled END_PC.
- Timeout: in RUN, when cycle_cnt==TIMEOUT_CYCLES-1 and no END_PC this cycle → TIMEOUT; done and timeout assert.
- Simultaneous events:
  - END_PC and timeout in the same cycle: END_PC wins.
  - A commit in the END_PC cycle is still counted and pushed.
- Terminal states freeze all counters and the trace. x0_write_err stays sticky.
- Trace read is combinational:
  - entry = mem[(wr_ptr-1-trace_rd_idx) mod TRACE_DEPTH].
  - Outputs are 0 when trace_rd_idx ≥ trace_count.
- Reset mid-run clears everything and returns to IDLE.

Decomposition:
- Package riscv_test_monitor_pkg holds:
  - state enum
  - trace entry struct {pc[31:0], wnum[4:0], wdata[31:0]}
  - RV_X0 constant
- Sub-module commit_trace_ring: holds the trace storage and wr_ptr/trace_count logic.
  - Inputs: push, entry, freeze, rd_idx.
  - Outputs: rd_entry, count.

Test Plan:
- Reset held, then released with pc_out stepping 0→4→8… and distinct wb_pc each cycle; reach pc_out=0x44 with reg3=1 → pass=1 and done=1 one cycle later, fail=0, fail_gp=1, retire_cnt equals the distinct nonzero wb_pc count.
- Same sequence but reg3=0x0000000D at 0x44 → fail=1, fail_gp=0x0000000D, pass=0.
- pc_out never reaches 0x44 with TIMEOUT_CYCLES=20 → timeout=1 after exactly 20 RUN cycles, cycle_cnt=19 frozen.
- Push 20 writes (wnum=i%31+1, wdata=i) with TRACE_DEPTH=16 → trace_count=16; idx 0 gives wdata=19; idx 15 gives wdata=4.
- Commit with wen=4'hF and wnum=0 → x0_write_err=1, trace_count unchanged. Same wb_pc held 3 cycles → retire_cnt +1 only.
- Assert rst mid-RUN after 5 commits → all outputs 0 immediately (async); next run counts from 0.
